// File: rtl/uart_rx_ctrl.sv
// Receive sequencer for a byte-level 8N1 UART datapath: start detection, mid-bit
// sample pulses, stop check, little-endian word packing and idle-timeout flush.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_en,
    input  logic        rxd,
    output logic        rx_rst_n,
    output logic        rx_enable,
    input  logic        rx_load,
    input  logic [7:0]  rx_byte,
    output logic [31:0] word_data,
    output logic [2:0]  word_bytes,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun,
    input  logic        err_clr
);

    localparam int BIT_W   = $clog2(CLKS_PER_BIT);
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    localparam logic [BIT_W-1:0] HALF_LD  = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, FLUSH} state_t;

    state_t             state;
    logic               rxd_p0, rxd_s, rxd_prev;
    logic [BIT_W-1:0]   bit_cnt;
    logic [3:0]         pulse_cnt;
    logic               stop_bit, stop_vld;
    logic               load_prev;
    logic               pend_vld;
    logic [7:0]         pend_byte;
    logic [2:0]         byte_cnt;
    logic [23:0]        asm_word;
    logic [TMO_W-1:0]   tmr;

    logic fall, load_rise, commit, pack, ferr_new, word_full, tmo_hit;
    logic deliver_req, out_free;

    function automatic logic [23:0] lane_mask(input logic [2:0] cnt);
        case (cnt)
            3'd1:    lane_mask = 24'h0000FF;
            3'd2:    lane_mask = 24'h00FFFF;
            default: lane_mask = 24'hFFFFFF;
        endcase
    endfunction

    assign rx_rst_n    = ~(reset | ~ctrl_en);
    assign fall        = rxd_prev & ~rxd_s;
    assign load_rise   = rx_load & ~load_prev;
    // A byte is committed only once both the datapath byte and its stop sample exist.
    assign commit      = ctrl_en & pend_vld & stop_vld & (state != FLUSH);
    assign pack        = commit & stop_bit;
    assign ferr_new    = commit & ~stop_bit;
    assign word_full   = pack & (byte_cnt == 3'd3);
    assign tmo_hit     = (state == IDLE) && (byte_cnt != 3'd0) && (tmr == TMO_LAST) && !commit;
    assign deliver_req = ctrl_en & (word_full | (state == FLUSH));
    assign out_free    = ~word_valid | word_ready;

    // Line synchronizer, idles high so reset never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_p0   <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_p0   <= rxd;
            rxd_s    <= rxd_p0;
            rxd_prev <= rxd_s;
        end
    end

    // Bit-timing sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pulse_cnt <= '0;
            rx_enable <= 1'b0;
            stop_bit  <= 1'b0;
            stop_vld  <= 1'b0;
        end else if (!ctrl_en) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pulse_cnt <= '0;
            rx_enable <= 1'b0;
            stop_bit  <= 1'b0;
            stop_vld  <= 1'b0;
        end else begin
            rx_enable <= 1'b0;
            if (commit)
                stop_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (tmo_hit) begin
                        state <= FLUSH;
                    end else if (fall) begin
                        bit_cnt <= HALF_LD;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (bit_cnt == '0) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            rx_enable <= 1'b1;
                            pulse_cnt <= 4'd1;
                            bit_cnt   <= BIT_LD;
                            state     <= RUN;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                RUN: begin
                    // Pulse 11 follows pulse 10 immediately to park the datapath inside the stop bit
                    if (pulse_cnt == 4'd10) begin
                        rx_enable <= 1'b1;
                        pulse_cnt <= 4'd0;
                        state     <= IDLE;
                    end else if (bit_cnt == '0) begin
                        rx_enable <= 1'b1;
                        pulse_cnt <= pulse_cnt + 4'd1;
                        bit_cnt   <= BIT_LD;
                        if (pulse_cnt == 4'd9) begin
                            stop_bit <= rxd_s;
                            stop_vld <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Byte capture, lane assembly and idle timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_prev <= 1'b0;
            pend_vld  <= 1'b0;
            byte_cnt  <= '0;
            tmr       <= '0;
        end else if (!ctrl_en) begin
            load_prev <= 1'b0;
            pend_vld  <= 1'b0;
            byte_cnt  <= '0;
            tmr       <= '0;
        end else begin
            load_prev <= rx_load;
            if (commit)
                pend_vld <= 1'b0;
            if (load_rise) begin
                pend_vld  <= 1'b1;
                pend_byte <= rx_byte;
            end
            if (pack) begin
                byte_cnt <= (byte_cnt == 3'd3) ? 3'd0 : byte_cnt + 3'd1;
                case (byte_cnt)
                    3'd0:    asm_word[7:0]   <= pend_byte;
                    3'd1:    asm_word[15:8]  <= pend_byte;
                    3'd2:    asm_word[23:16] <= pend_byte;
                    default: ;
                endcase
                tmr <= '0;
            end else if (state == FLUSH) begin
                byte_cnt <= '0;
                tmr      <= '0;
            end else if (state == IDLE && byte_cnt != 3'd0) begin
                tmr <= tmr + TMO_W'(1);
            end
        end
    end

    // Output word register and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_data  <= '0;
            word_bytes <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            if (deliver_req && out_free) begin
                word_valid <= 1'b1;
                if (word_full) begin
                    word_data  <= {pend_byte, asm_word};
                    word_bytes <= 3'd4;
                end else begin
                    word_data  <= {8'h00, asm_word & lane_mask(byte_cnt)};
                    word_bytes <= byte_cnt;
                end
            end
            frame_err <= (frame_err & ~err_clr) | ferr_new;
            overrun   <= (overrun & ~err_clr) | (deliver_req & ~out_free);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the 8N1 shift datapath and scoreboards delivered words.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset, ctrl_en, rxd, err_clr, word_ready;
    logic        rx_rst_n, rx_enable, rx_load, word_valid, frame_err, overrun;
    logic [7:0]  rx_byte;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;

    int checks = 0, failures = 0;
    int cyc = 0, en_total = 0, pidx = 0, plast = 0, words_seen = 0;
    int dp_cnt = 0;
    logic [7:0]  dp_sh = 8'h00;
    logic [34:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO)) dut (
        .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .rxd(rxd),
        .rx_rst_n(rx_rst_n), .rx_enable(rx_enable), .rx_load(rx_load), .rx_byte(rx_byte),
        .word_data(word_data), .word_bytes(word_bytes), .word_valid(word_valid),
        .word_ready(word_ready), .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Datapath model: pulse 1 start, 2..9 data LSB first, load after pulse 9, idle after pulse 11
    always @(posedge clk) begin
        if (!rx_rst_n) begin
            dp_cnt  <= 0;
            rx_load <= 1'b0;
        end else if (rx_enable) begin
            if (dp_cnt >= 1 && dp_cnt <= 8)
                dp_sh <= {rxd, dp_sh[7:1]};
            if (dp_cnt == 8)
                rx_load <= 1'b1;
            if (dp_cnt == 10) begin
                dp_cnt  <= 0;
                rx_load <= 1'b0;
            end else begin
                dp_cnt <= dp_cnt + 1;
            end
        end
    end
    assign rx_byte = dp_sh;

    // Pulse spacing monitor and word scoreboard
    always @(negedge clk) begin
        logic [34:0] e;
        cyc++;
        if (!rx_rst_n) begin
            pidx = 0;
        end else if (rx_enable) begin
            en_total++;
            pidx++;
            if (pidx > 1)
                chk_eq("en_gap", cyc - plast, (pidx == 11) ? 1 : CPB);
            plast = cyc;
            if (pidx == 11)
                pidx = 0;
        end
        if (word_valid && word_ready) begin
            chk_eq("sb_avail", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk_eq("word_data", word_data, e[31:0]);
                chk_eq("word_bytes", 32'(word_bytes), 32'(e[34:32]));
            end
            words_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
        sb.push_back({n, d});
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++)
            tick(1);
        chk_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, w0;
        reset = 1'b1; ctrl_en = 1'b1; rxd = 1'b1; word_ready = 1'b1; err_clr = 1'b0;
        tick(3);
        chk_eq("rst_valid", word_valid, 0);
        chk_eq("rst_data", word_data, 0);
        chk_eq("rst_bytes", word_bytes, 0);
        chk_eq("rst_ferr", frame_err, 0);
        chk_eq("rst_ovr", overrun, 0);
        chk_eq("rst_en", rx_enable, 0);
        chk_eq("rst_rstn", rx_rst_n, 0);
        reset = 1'b0;
        tick(4);
        chk_eq("rstn_release", rx_rst_n, 1);

        // Full word with consumer ready
        e0 = en_total;
        expect_word(32'h44434241, 3'd4);
        send_byte(8'h41, 1'b1); send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1); send_byte(8'h44, 1'b1);
        drive_bit(1'b1);
        wait_drain(200);
        chk_eq("valid_one_cycle", word_valid, 0);
        chk_eq("pulses_4bytes", en_total - e0, 44);

        // Partial word flushed on idle timeout
        expect_word(32'h00005AA5, 3'd2);
        w0 = words_seen;
        send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1);
        tick(30 * CPB);
        chk_eq("no_early_flush", words_seen, w0);
        wait_drain(20 * CPB);

        // Stop bit low: flagged and dropped
        send_byte(8'h3C, 1'b0);
        drive_bit(1'b1); drive_bit(1'b1);
        chk_eq("ferr_set", frame_err, 1);
        chk_eq("ferr_no_word", word_valid, 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        chk_eq("ferr_clr", frame_err, 0);
        expect_word(32'h04030201, 3'd4);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        drive_bit(1'b1);
        wait_drain(200);

        // Overrun with consumer stalled
        word_ready = 1'b0;
        expect_word(32'h13121110, 3'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        drive_bit(1'b1);
        chk_eq("held_valid", word_valid, 1);
        chk_eq("held_data", word_data, 32'h13121110);
        chk_eq("ovr_clear_before", overrun, 0);
        for (int i = 4; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
        drive_bit(1'b1);
        chk_eq("ovr_set", overrun, 1);
        chk_eq("ovr_data_kept", word_data, 32'h13121110);
        chk_eq("ovr_bytes_kept", word_bytes, 4);
        w0 = words_seen;
        word_ready = 1'b1;
        wait_drain(10);
        for (int i = 0; i < TMO + 5; i++) drive_bit(1'b1);
        chk_eq("ovr_no_flush", words_seen, w0 + 1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        chk_eq("ovr_clr", overrun, 0);

        // Short glitch in idle
        e0 = en_total;
        rxd = 1'b0; tick(5); rxd = 1'b1; tick(3 * CPB);
        chk_eq("glitch_pulses", en_total - e0, 0);
        chk_eq("glitch_load", rx_load, 0);

        // Abort after start plus three data bits
        e0 = en_total;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        ctrl_en = 1'b0;
        tick(1);
        chk_eq("abort_rstn", rx_rst_n, 0);
        e1 = en_total;
        chk_eq("abort_pulses", e1 - e0, 4);
        for (int i = 0; i < 6; i++) drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1);
        chk_eq("abort_quiet", en_total, e1);
        ctrl_en = 1'b1;
        tick(2);
        expect_word(32'h11111111, 3'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
        drive_bit(1'b1);
        wait_drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
